// File: rtl/minmax_tracker_pkg.sv
// Shared types and constants for the min/max statistics stage.
package minmax_tracker_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    TRACK  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

  localparam logic [DEF_WIDTH-1:0] MIN_SENTINEL = '1;

endpackage

// File: rtl/minmax_tracker_if.sv
// Sample-in / result-out handshake bundle for minmax_tracker.
interface minmax_tracker_if
  import minmax_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             dump;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_max;
  logic [WIDTH-1:0] res_min;
  logic [CNT_W-1:0] res_count;
  logic             res_sat;
  logic             new_max;
  logic             new_min;

  modport master (
    output clear, in_valid, in_data, dump, res_ready,
    input  in_ready, res_valid, res_max, res_min, res_count, res_sat,
           new_max, new_min
  );

  modport slave (
    input  clear, in_valid, in_data, dump, res_ready,
    output in_ready, res_valid, res_max, res_min, res_count, res_sat,
           new_max, new_min
  );

endinterface

// File: rtl/minmax_tracker_mag_cmp.sv
// Combinational unsigned magnitude comparator, MSB-first cascade.
module mag_cmp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  always_comb begin
    logic higher_eq;
    higher_eq = 1'b1;
    gt        = 1'b0;
    lt        = 1'b0;
    // The first differing bit from the top decides; lower bits are masked once decided.
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (higher_eq) begin
        if (a[WIDTH-1-k] && !b[WIDTH-1-k]) gt = 1'b1;
        if (!a[WIDTH-1-k] && b[WIDTH-1-k]) lt = 1'b1;
      end
      higher_eq = higher_eq && (a[WIDTH-1-k] == b[WIDTH-1-k]);
    end
    eq = higher_eq;
  end

endmodule

// File: rtl/minmax_tracker.sv
// Running max/min/count over a sample stream, frozen into a report on dump.
module minmax_tracker
  import minmax_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst,
  minmax_tracker_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_INIT = '0;
  localparam logic [WIDTH-1:0] MIN_INIT = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_r, state_n;
  logic [WIDTH-1:0] max_r, max_n;
  logic [WIDTH-1:0] min_r, min_n;
  logic [CNT_W-1:0] count_r, count_n;
  logic             sat_r, sat_n;
  logic             new_max_r, new_max_n;
  logic             new_min_r, new_min_n;

  logic eq_max, gt_max, lt_max;
  logic eq_min, gt_min, lt_min;
  logic accept;
  logic unused_cmp;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (bus.in_data),
    .b  (max_r),
    .eq (eq_max),
    .gt (gt_max),
    .lt (lt_max)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (bus.in_data),
    .b  (min_r),
    .eq (eq_min),
    .gt (gt_min),
    .lt (lt_min)
  );

  assign unused_cmp = eq_max | lt_max | eq_min | gt_min;

  assign bus.in_ready  = (state_r != REPORT);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.res_valid = (state_r == REPORT);
  assign bus.res_max   = max_r;
  assign bus.res_min   = min_r;
  assign bus.res_count = count_r;
  assign bus.res_sat   = sat_r;
  assign bus.new_max   = new_max_r;
  assign bus.new_min   = new_min_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= EMPTY;
      max_r     <= MAX_INIT;
      min_r     <= MIN_INIT;
      count_r   <= '0;
      sat_r     <= 1'b0;
      new_max_r <= 1'b0;
      new_min_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      max_r     <= max_n;
      min_r     <= min_n;
      count_r   <= count_n;
      sat_r     <= sat_n;
      new_max_r <= new_max_n;
      new_min_r <= new_min_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    max_n     = max_r;
    min_n     = min_r;
    count_n   = count_r;
    sat_n     = sat_r;
    new_max_n = 1'b0;
    new_min_n = 1'b0;

    if (bus.clear) begin
      state_n = EMPTY;
      max_n   = MAX_INIT;
      min_n   = MIN_INIT;
      count_n = '0;
      sat_n   = 1'b0;
    end else begin
      if (accept) begin
        if (state_r == EMPTY) begin
          max_n     = bus.in_data;
          min_n     = bus.in_data;
          count_n   = CNT_W'(1);
          new_max_n = 1'b1;
          new_min_n = 1'b1;
          state_n   = TRACK;
        end else begin
          if (gt_max) begin
            max_n     = bus.in_data;
            new_max_n = 1'b1;
          end
          if (lt_min) begin
            min_n     = bus.in_data;
            new_min_n = 1'b1;
          end
          if (count_r == CNT_MAX) sat_n = 1'b1;
          else                    count_n = count_r + CNT_W'(1);
        end
      end

      // A dump in the same cycle as an accept still reports that sample.
      if (bus.dump && (state_r != REPORT)) begin
        state_n = REPORT;
      end else if ((state_r == REPORT) && bus.res_ready) begin
        state_n = EMPTY;
        max_n   = MAX_INIT;
        min_n   = MIN_INIT;
        count_n = '0;
        sat_n   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed and random stimulus for minmax_tracker against a sample-history model.
module tb_minmax_tracker;
  import minmax_tracker_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  minmax_tracker_if #(.WIDTH(4), .CNT_W(8)) bus8 ();
  minmax_tracker_if #(.WIDTH(4), .CNT_W(3)) bus3 ();

  minmax_tracker #(.WIDTH(4), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  minmax_tracker #(.WIDTH(4), .CNT_W(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_err = 0;
  int n_chk = 0;
  int q[$];
  bit rep = 1'b0;
  bit exp_nmax = 1'b0;
  bit exp_nmin = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int q_max();
    int m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  function automatic int q_min();
    int m = int'(MIN_SENTINEL);
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    rep = 1'b0;
    exp_nmax = 1'b0;
    exp_nmin = 1'b0;
  endtask

  task automatic chk_all(input string tag);
    int cnt;
    cnt = (q.size() > 255) ? 255 : q.size();
    chk({tag, ".in_ready"},  32'(bus8.in_ready),  32'(!rep));
    chk({tag, ".res_valid"}, 32'(bus8.res_valid), 32'(rep));
    chk({tag, ".res_max"},   32'(bus8.res_max),   32'(q_max()));
    chk({tag, ".res_min"},   32'(bus8.res_min),   32'(q_min()));
    chk({tag, ".res_count"}, 32'(bus8.res_count), 32'(cnt));
    chk({tag, ".res_sat"},   32'(bus8.res_sat),   32'(q.size() > 255));
    chk({tag, ".new_max"},   32'(bus8.new_max),   32'(exp_nmax));
    chk({tag, ".new_min"},   32'(bus8.new_min),   32'(exp_nmin));
  endtask

  task automatic drive(input bit v, input int d, input bit dm, input bit rr, input bit cl);
    bus8.in_valid  = v;
    bus8.in_data   = 4'(d);
    bus8.dump      = dm;
    bus8.res_ready = rr;
    bus8.clear     = cl;
  endtask

  task automatic step8(input string tag);
    bit old;
    int d;
    chk({tag, ".pre_in_ready"}, 32'(bus8.in_ready), 32'(!rep));
    @(posedge clk);
    exp_nmax = 1'b0;
    exp_nmin = 1'b0;
    old = rep;
    if (bus8.clear) begin
      q.delete();
      rep = 1'b0;
    end else begin
      if (bus8.in_valid && !old) begin
        d = int'(bus8.in_data);
        exp_nmax = (q.size() == 0) || (d > q_max());
        exp_nmin = (q.size() == 0) || (d < q_min());
        q.push_back(d);
      end
      if (bus8.dump && !old) rep = 1'b1;
      else if (old && bus8.res_ready) begin
        rep = 1'b0;
        q.delete();
      end
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    int stream[5] = '{9, 12, 3, 12, 3};
    int prev_max, prev_min, prev_cnt;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.dump = 1'b0;
    bus3.res_ready = 1'b0; bus3.clear = 1'b0;
    model_reset();
    #12 rst = 1'b0;
    chk_all("reset");

    // Stream 9,12,3,12,3 then dump
    foreach (stream[i]) begin
      drive(1, stream[i], 0, 0, 0);
      step8("stream");
    end
    drive(0, 0, 1, 0, 0);
    step8("dump1");
    chk("dump1.max12", 32'(bus8.res_max), 32'd12);
    chk("dump1.min3",  32'(bus8.res_min), 32'd3);
    chk("dump1.cnt5",  32'(bus8.res_count), 32'd5);
    drive(0, 0, 0, 1, 0);
    step8("handoff1");

    // Stream 4,6 then 15 together with dump
    drive(1, 4, 0, 0, 0);  step8("s4");
    drive(1, 6, 0, 0, 0);  step8("s6");
    drive(1, 15, 1, 0, 0); step8("s15dump");
    chk("s15dump.max15", 32'(bus8.res_max), 32'd15);
    chk("s15dump.cnt3",  32'(bus8.res_count), 32'd3);

    // Back-pressure in REPORT: samples ignored, record stable
    prev_max = int'(bus8.res_max); prev_min = int'(bus8.res_min); prev_cnt = int'(bus8.res_count);
    for (int i = 0; i < 3; i++) begin
      drive(i != 1, 1, 0, 0, 0);
      step8("hold");
    end
    chk("hold.max_stable", 32'(bus8.res_max), 32'(prev_max));
    chk("hold.min_stable", 32'(bus8.res_min), 32'(prev_min));
    chk("hold.cnt_stable", 32'(bus8.res_count), 32'(prev_cnt));
    drive(0, 0, 0, 1, 0); step8("handoff2");
    chk("handoff2.cnt0", 32'(bus8.res_count), 32'd0);

    // Dump while empty gives sentinel record
    drive(0, 0, 1, 0, 0); step8("dump_empty");
    chk("dump_empty.min", 32'(bus8.res_min), 32'hF);
    drive(0, 0, 1, 1, 0); step8("dump_in_report");
    drive(0, 0, 0, 0, 0); step8("idle");

    // Async reset between edges in TRACK
    drive(1, 7, 0, 0, 0); step8("pre_rst_a");
    drive(1, 2, 0, 0, 0); step8("pre_rst_b");
    drive(0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #1 model_reset();
    chk_all("async_rst");
    #1 rst = 1'b0;
    step8("post_rst");

    // Clear while a report is pending
    drive(1, 10, 1, 0, 0); step8("pre_clear");
    drive(0, 0, 0, 0, 1);  step8("clear_report");
    drive(1, 3, 0, 0, 1);  step8("clear_with_accept");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, int'($urandom % 16), ($urandom % 8) == 0,
            ($urandom % 2) == 1, ($urandom % 32) == 0);
      step8("rand");
    end
    drive(0, 0, 0, 0, 0);

    // Saturation on the 3-bit counter instance
    for (int i = 0; i < 9; i++) begin
      bus3.in_valid = 1'b1;
      bus3.in_data  = 4'd5;
      @(posedge clk); #1;
      chk("sat.new_max", 32'(bus3.new_max), 32'(i == 0));
      chk("sat.new_min", 32'(bus3.new_min), 32'(i == 0));
      chk("sat.count",   32'(bus3.res_count), 32'((i + 1 > 7) ? 7 : i + 1));
      chk("sat.sat",     32'(bus3.res_sat), 32'(i + 1 > 7));
    end
    bus3.in_valid = 1'b0;
    bus3.dump = 1'b1;
    @(posedge clk); #1;
    bus3.dump = 1'b0;
    chk("sat.res_valid", 32'(bus3.res_valid), 32'd1);
    chk("sat.res_count", 32'(bus3.res_count), 32'd7);
    chk("sat.res_sat",   32'(bus3.res_sat), 32'd1);
    chk("sat.res_max",   32'(bus3.res_max), 32'd5);
    chk("sat.res_min",   32'(bus3.res_min), 32'd5);
    bus3.res_ready = 1'b1;
    @(posedge clk); #1;
    bus3.res_ready = 1'b0;
    chk("sat.handoff_valid", 32'(bus3.res_valid), 32'd0);
    chk("sat.handoff_sat",   32'(bus3.res_sat), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
Streaming statistics stage sitting directly downstream of the 4-bit magnitude comparator in the ALU datapath.
- Accepts a stream of WIDTH-bit unsigned samples over a valid/ready handshake.
- Uses comparator eq/greater/lesser results to maintain a running maximum, minimum and sample count.
- On request, freezes the statistics into a result record, handed off over a second valid/ready handshake; then self-clears.

Parameters:
WIDTH, 4, sample width in bits (unsigned)
CNT_W, 8, sample counter width; counter saturates at 2^CNT_W-1

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
clear  input  1  synchronous discard of all statistics and any pending report
in_valid  input  1  sample present on in_data
in_ready  output  1  block can accept a sample
in_data  input  WIDTH  unsigned sample
dump  input  1  request report of current statistics
res_valid  output  1  result record valid
res_ready  input  1  downstream accepts result record
res_max  output  WIDTH  maximum sample seen
res_min  output  WIDTH  minimum sample seen
res_count  output  CNT_W  number of accepted samples (saturating)
res_sat  output  1  sticky: count saturated
new_max  output  1  one-cycle pulse: last accepted sample raised the maximum
new_min  output  1  one-cycle pulse: last accepted sample lowered the minimum

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high, in effect immediately and independent of `clk`.
- rst: state=EMPTY; max=0; min=all-ones; count=0; sat=0; res_valid=0; new_max=new_min=0. in_ready=1 after release.
- States: EMPTY (no samples), TRACK (at least one sample), REPORT (record held for downstream).
- in_ready = (state != REPORT), combinational from state only. Accept = in_valid & in_ready.
- Priority per cycle: rst > clear > accept > dump > res handshake.
- EMPTY, accept:
  - max=min=in_data, count=1, state→TRACK.
  - new_max=new_min=1 on the next cycle.
- TRACK, accept, using the comparator against the stored max and min:
  - in_data > max → max=in_data, new_max pulse.
  - in_data < min → min=in_data, new_min pulse.
  - Equal values: no update, no pulse.
  - count+1, saturating at 2^CNT_W-1. The first increment attempted at saturation sets sat (sticky until cleared).
- Pulses are registered: high exactly the cycle after the accepting edge, otherwise 0.
- Statistics latency: 1 cycle. A sample accepted at edge N is reflected in max/min/count after edge N.
- dump in EMPTY or TRACK:
  - state→REPORT; res_valid=1 from the next cycle.
  - A sample accepted in the same cycle as dump is included in the report.
- dump in EMPTY: a valid report with count=0, max=0, min=all-ones (sentinels), sat=0.
- dump while in REPORT is ignored.
- REPORT:
  - res_* stable while res_valid & !res_ready.
  - On res_valid & res_ready: statistics reset to their reset values, state→EMPTY, res_valid=0 next cycle.
  - New samples are accepted from the cycle after handoff.
- res_max/res_min/res_count/res_sat always show the live registers. They are only meaningful while res_valid=1.
- clear in any state: same values as rst, synchronously. A pending report is discarded without a handshake, and pulses are suppressed.
- rst mid-operation (any state): immediate return to reset values. Any in-flight handshake is abandoned.

Decomposition:
- Shared package:
  - state enum {EMPTY, TRACK, REPORT};
  - default WIDTH and CNT_W constants;
  - min sentinel constant (all-ones of WIDTH).
- One sub-module, mag_cmp: a combinational WIDTH-bit unsigned comparator with eq/gt/lt outputs.
  - Two instances: sample vs max, sample vs min.
  - Its cascade must give the same truth as the datapath 4-bit comparator at WIDTH=4.

Test Plan:
- Reset, then stream 9,12,3,12,3, then dump → res_max=12, res_min=3, res_count=5, res_sat=0. new_max pulses after samples 1,2; new_min pulses after samples 1,3; no pulses on the repeats.
- Sample 15 accepted in the same cycle as dump, after stream 4,6 → REPORT with res_max=15, res_min=4, res_count=3.
- Hold res_ready=0 for 3 cycles in REPORT → in_ready=0, in_valid pulses ignored, res_* stable. Then res_ready=1 → next cycle res_valid=0, state EMPTY, count=0.
- dump immediately after reset → res_valid=1, res_count=0, res_max=0x0, res_min=0xF.
- CNT_W=3, stream 9 samples of value 5 → res_count=7, res_sat=1, max=min=5. Only sample 1 produces pulses.
- Async rst asserted between edges mid-TRACK → outputs at reset values before the next edge. clear asserted in REPORT → res_valid=0 next cycle, in_ready=1, count=0.
